// File: rtl/mem_access_unit.sv
// Memory-stage responder: owns the data memory and stack pointer, services
// LDD/STD/PUSH/POP requests and returns load/pop data with the captured tag and flags.
module mem_access_unit #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SP_RESET = 2047
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_dst,
  input  logic [2:0]        req_ccr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        rsp_dst,
  output logic [2:0]        rsp_ccr,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_RESET);
  localparam logic [2:0] OP_LDD  = 3'b001;
  localparam logic [2:0] OP_STD  = 3'b010;
  localparam logic [2:0] OP_PUSH = 3'b011;
  localparam logic [2:0] OP_POP  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]        rsp_dst_q, rsp_dst_d;
  logic [2:0]        rsp_ccr_q, rsp_ccr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              stack_err_q, stack_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic accept;
  logic unused_addr_bits;

  assign unused_addr_bits = ^req_addr[15:ADDR_W];
  assign req_ready        = (state_q == IDLE);
  assign accept           = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    rd_addr_d   = rd_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_dst_d   = rsp_dst_q;
    rsp_ccr_d   = rsp_ccr_q;
    rsp_valid_d = 1'b0;
    stack_err_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = req_addr[ADDR_W-1:0];
    mem_wdata   = req_wdata;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (req_op)
            OP_LDD: begin
              rd_addr_d = req_addr[ADDR_W-1:0];
              rsp_dst_d = req_dst;
              rsp_ccr_d = req_ccr;
              state_d   = RD;
            end
            OP_STD: mem_we = 1'b1;
            OP_PUSH: begin
              if (sp_q == '0) begin
                stack_err_d = 1'b1;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = sp_q;
                sp_d      = sp_q - ADDR_W'(1);
              end
            end
            OP_POP: begin
              if (sp_q == SP_INIT) begin
                stack_err_d = 1'b1;
              end else begin
                sp_d      = sp_q + ADDR_W'(1);
                rd_addr_d = sp_q + ADDR_W'(1);
                rsp_dst_d = req_dst;
                rsp_ccr_d = req_ccr;
                state_d   = RD;
              end
            end
            default: ;
          endcase
        end
      end
      RD: begin
        rsp_data_d = mem[rd_addr_q];
        state_d    = RSP;
      end
      RSP: begin
        // Valid is registered out of RSP so the requester may issue again in the response cycle.
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sp_q        <= SP_INIT;
      rd_addr_q   <= '0;
      rsp_data_q  <= '0;
      rsp_dst_q   <= '0;
      rsp_ccr_q   <= '0;
      rsp_valid_q <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      rd_addr_q   <= rd_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_dst_q   <= rsp_dst_d;
      rsp_ccr_q   <= rsp_ccr_d;
      rsp_valid_q <= rsp_valid_d;
      stack_err_q <= stack_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_dst   = rsp_dst_q;
  assign rsp_ccr   = rsp_ccr_q;
  assign sp        = sp_q;
  assign stack_err = stack_err_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage responder that services the address/data requests produced by the execute-side memory instruction units (LDD, STD, PUSH, POP).
- Owns the data memory array and the stack pointer.
- Performs the access and returns load/pop data together with the destination register tag and the flags captured with the request.
- Sits between the execute/memory pipeline register and the write-back stage.

Parameters:
- ADDR_W, 11, word-address width of the data memory (depth 2^ADDR_W words).
- DATA_W, 16, memory word and data bus width.
- SP_RESET, 2047, stack pointer value after reset (top of memory, 2^ADDR_W-1).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_op  input  3  000 NOP, 001 LDD, 010 STD, 011 PUSH, 100 POP; others treated as NOP.
- req_addr  input  16  effective address for LDD/STD; only bits [ADDR_W-1:0] are used.
- req_wdata  input  DATA_W  store/push data.
- req_dst  input  3  destination register index for LDD/POP.
- req_ccr  input  3  flags travelling with the instruction.
- rsp_valid  output  1  one-cycle pulse: load/pop data valid.
- rsp_data  output  DATA_W  read data.
- rsp_dst  output  3  destination register of the response.
- rsp_ccr  output  3  flags captured at accept, returned unchanged.
- sp  output  ADDR_W  current stack pointer.
- stack_err  output  1  one-cycle pulse on a rejected PUSH/POP.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, sp=SP_RESET.
  - req_ready=1 (combinational from IDLE).
  - rsp_valid=0, rsp_data=0, rsp_dst=0, rsp_ccr=0, stack_err=0.
  - Memory contents are not reset.
- Accept: a request is accepted on the rising edge where req_valid=1 and req_ready=1. req_ready=1 only in IDLE.
- States:
  - IDLE: accept of LDD or POP -> RD. Any other accept, or no accept -> IDLE.
  - RD: synchronous memory read of the latched address; data registered -> RSP.
  - RSP: rsp_valid=1 for exactly one cycle -> IDLE.
- Load latency: accepted at edge N; rsp_valid high during the cycle after edge N+2. Next request can be accepted at edge N+3.
- STD:
  - mem[req_addr[ADDR_W-1:0]] <= req_wdata at the accept edge.
  - Single cycle, no response, stays IDLE.
- PUSH:
  - mem[sp] <= req_wdata and sp <= sp-1 at the accept edge.
  - No response.
- POP:
  - sp <= sp+1 at the accept edge; the read address is the incremented sp.
  - Response follows the load timing.
- Request latch: rsp_dst and rsp_ccr are latched at accept and held until the next accepted LDD/POP. rsp_data is updated at the RD->RSP edge and held after.
- Boundaries:
  - PUSH with sp==0: no write, sp unchanged, stack_err pulses 1 cycle, stays IDLE.
  - POP with sp==SP_RESET: sp unchanged, no read, no response, stack_err pulses, stays IDLE.
  - No wrap-around of sp under any op.
- NOP or unknown op: accepted with no effect. req_wdata, req_addr and req_dst are ignored for ops that don't use them.
- Address width: LDD/STD addresses are truncated to ADDR_W bits (aliasing is intended). sp arithmetic is ADDR_W bits.
- Reset mid-operation: reset_n low in RD or RSP aborts the access.
  - No rsp_valid is ever produced for the aborted request.
  - sp returns to SP_RESET.
  - Writes completed before reset persist.
- req_valid while not ready: ignored. The requester must hold it; nothing is queued.

Test Plan:
- Reset, then STD addr=0x0010 data=0xBEEF, then LDD addr=0x0010 dst=3 ccr=101 -> rsp_valid exactly 2 edges after LDD accept, rsp_data=0xBEEF, rsp_dst=3, rsp_ccr=101; req_ready low for 2 cycles.
- PUSH 0x1111, PUSH 0x2222, POP dst=1, POP dst=2 -> sp 2047→2046→2045→2046→2047; responses 0x2222 then 0x1111; mem[2047]=0x1111.
- POP right after reset -> stack_err pulse, sp=2047, no rsp_valid. Drive sp to 0 with 2047 PUSHes, then PUSH 0xAAAA -> stack_err pulse, sp=0, mem[0] unchanged.
- LDD addr=0x0810 after STD addr=0x0010 data=0x1234 -> rsp_data=0x1234 (upper-bit aliasing).
- Accept LDD, assert reset_n=0 during RD, release -> no rsp_valid, sp=2047, req_ready=1 immediately after release.
- req_valid held high with back-to-back LDDs -> each accepted only when req_ready=1 (every 3rd edge); no requests lost or duplicated; ops 101/110/111 -> no state, sp or memory change.
